// File: rtl/csr_write_buffer.sv
// rtl/csr_write_buffer.sv - speculative CSR write buffer with commit and forwarding
//
// Purpose: holds CSR results from execute until the active list retires the
// owning instruction, then drives the CSR file write port. Pending values are
// forwarded to the register-read stage's CSR lookup. Flushed on recovery.
//
// Ports:
//   clk, reset               core clock, synchronous active-high reset
//   recoverFlag_i            flush all uncommitted entries
//   exeValid_i/Addr/Data/AlID  CSR result offered by execute
//   full_o                   no free entry
//   commitValid_i/AlID       active list retires a CSR instruction
//   csrWrEn_o/Addr/Data      registered CSR file write port
//   csrRdEn_i/Addr           lookup from register-read stage
//   fwdHit_o/fwdData_o       youngest pending match for the lookup
//   commitErr_o              sticky protocol error flag
module csr_write_buffer #(
  parameter int DEPTH               = 4,
  parameter int CSR_WIDTH           = 32,
  parameter int CSR_WIDTH_LOG       = 12,
  parameter int SIZE_ACTIVELIST_LOG = 7
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           recoverFlag_i,
  input  logic                           exeValid_i,
  input  logic [CSR_WIDTH_LOG-1:0]       exeAddr_i,
  input  logic [CSR_WIDTH-1:0]           exeData_i,
  input  logic [SIZE_ACTIVELIST_LOG-1:0] exeAlID_i,
  output logic                           full_o,
  input  logic                           commitValid_i,
  input  logic [SIZE_ACTIVELIST_LOG-1:0] commitAlID_i,
  output logic                           csrWrEn_o,
  output logic [CSR_WIDTH_LOG-1:0]       csrWrAddr_o,
  output logic [CSR_WIDTH-1:0]           csrWrData_o,
  input  logic                           csrRdEn_i,
  input  logic [CSR_WIDTH_LOG-1:0]       csrRdAddr_i,
  output logic                           fwdHit_o,
  output logic [CSR_WIDTH-1:0]           fwdData_o,
  output logic                           commitErr_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0]               validQ;
  logic [CSR_WIDTH_LOG-1:0]       addrQ [DEPTH];
  logic [CSR_WIDTH-1:0]           dataQ [DEPTH];
  logic [SIZE_ACTIVELIST_LOG-1:0] alIdQ [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic                     wrEn;
  logic [CSR_WIDTH_LOG-1:0] wrAddr;
  logic [CSR_WIDTH-1:0]     wrData;
  logic                     errFlag;

  logic full;
  logic commitOk;
  logic enqOk;
  logic errEvent;

  assign full     = (count == CNT_W'(DEPTH));
  assign commitOk = commitValid_i && validQ[head] && (alIdQ[head] == commitAlID_i);
  // A pop in the same cycle frees the head slot, so a full buffer can still accept.
  assign enqOk    = exeValid_i && (!full || commitOk);
  assign errEvent = (commitValid_i && !commitOk) || (exeValid_i && full && !commitOk);

  always_ff @(posedge clk) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      validQ  <= '0;
      wrEn    <= 1'b0;
      wrAddr  <= '0;
      wrData  <= '0;
      errFlag <= 1'b0;
    end else begin
      wrEn <= commitOk;
      if (commitOk) begin
        wrAddr <= addrQ[head];
        wrData <= dataQ[head];
      end
      if (errEvent) begin
        errFlag <= 1'b1;
      end

      if (recoverFlag_i) begin
        // The legal commit above still writes; everything else is discarded.
        validQ <= '0;
        head   <= tail;
        count  <= '0;
      end else begin
        if (commitOk) begin
          validQ[head] <= 1'b0;
          head         <= head + PTR_W'(1);
        end
        // Placed after the pop so a full-buffer enqueue into the freed slot wins.
        if (enqOk) begin
          validQ[tail] <= 1'b1;
          addrQ[tail]  <= exeAddr_i;
          dataQ[tail]  <= exeData_i;
          alIdQ[tail]  <= exeAlID_i;
          tail         <= tail + PTR_W'(1);
        end
        case ({enqOk, commitOk})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Walk from oldest to youngest so the last match seen is the youngest.
  logic [PTR_W-1:0]     idx;
  logic                 hit;
  logic [CSR_WIDTH-1:0] hitData;

  always_comb begin
    idx     = head;
    hit     = 1'b0;
    hitData = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (csrRdEn_i && validQ[idx] && (addrQ[idx] == csrRdAddr_i)) begin
        hit     = 1'b1;
        hitData = dataQ[idx];
      end
    end
  end

  assign full_o      = full;
  assign csrWrEn_o   = wrEn;
  assign csrWrAddr_o = wrAddr;
  assign csrWrData_o = wrData;
  assign fwdHit_o    = hit;
  assign fwdData_o   = hitData;
  assign commitErr_o = errFlag;

endmodule

// File: tb/tb_csr_write_buffer.sv
// tb/tb_csr_write_buffer.sv - table-driven self-checking bench for csr_write_buffer
module tb_csr_write_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        recoverFlag;
  logic        exeValid;
  logic [11:0] exeAddr;
  logic [31:0] exeData;
  logic [6:0]  exeAlID;
  logic        full;
  logic        commitValid;
  logic [6:0]  commitAlID;
  logic        csrWrEn;
  logic [11:0] csrWrAddr;
  logic [31:0] csrWrData;
  logic        csrRdEn;
  logic [11:0] csrRdAddr;
  logic        fwdHit;
  logic [31:0] fwdData;
  logic        commitErr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  csr_write_buffer #(
    .DEPTH(4), .CSR_WIDTH(32), .CSR_WIDTH_LOG(12), .SIZE_ACTIVELIST_LOG(7)
  ) dut (
    .clk(clk), .reset(reset), .recoverFlag_i(recoverFlag),
    .exeValid_i(exeValid), .exeAddr_i(exeAddr), .exeData_i(exeData), .exeAlID_i(exeAlID),
    .full_o(full), .commitValid_i(commitValid), .commitAlID_i(commitAlID),
    .csrWrEn_o(csrWrEn), .csrWrAddr_o(csrWrAddr), .csrWrData_o(csrWrData),
    .csrRdEn_i(csrRdEn), .csrRdAddr_i(csrRdAddr), .fwdHit_o(fwdHit), .fwdData_o(fwdData),
    .commitErr_o(commitErr)
  );

  typedef struct {
    logic        chk;
    logic        rst;
    logic        rec;
    logic        ev;
    logic [11:0] ea;
    logic [31:0] ed;
    logic [6:0]  eal;
    logic        cv;
    logic [6:0]  cal;
    logic        ren;
    logic [11:0] ra;
    logic        xFull;
    logic        xWr;
    logic [11:0] xWa;
    logic [31:0] xWd;
    logic        xHit;
    logic [31:0] xFd;
    logic        xErr;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=0x%0h expected=0x%0h", name, row, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic rec, input logic ev, input logic [11:0] ea,
                       input logic [31:0] ed, input logic [6:0] eal, input logic cv,
                       input logic [6:0] cal, input logic ren, input logic [11:0] ra);
    reset = rst; recoverFlag = rec; exeValid = ev; exeAddr = ea; exeData = ed; exeAlID = eal;
    commitValid = cv; commitAlID = cal; csrRdEn = ren; csrRdAddr = ra;
  endtask

  // Row helper: inputs, then expected outputs observed during the same cycle.
  function automatic void row(logic chk, logic rst, logic rec, logic ev, logic [11:0] ea,
                              logic [31:0] ed, logic [6:0] eal, logic cv, logic [6:0] cal,
                              logic ren, logic [11:0] ra, logic xFull, logic xWr,
                              logic [11:0] xWa, logic [31:0] xWd, logic xHit,
                              logic [31:0] xFd, logic xErr);
    vec_t v;
    v.chk = chk; v.rst = rst; v.rec = rec; v.ev = ev; v.ea = ea; v.ed = ed; v.eal = eal;
    v.cv = cv; v.cal = cal; v.ren = ren; v.ra = ra; v.xFull = xFull; v.xWr = xWr;
    v.xWa = xWa; v.xWd = xWd; v.xHit = xHit; v.xFd = xFd; v.xErr = xErr;
    vecs.push_back(v);
  endfunction

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    //  chk rst rec ev  ea     ed    eal cv cal ren ra     full wr wa     wd    hit fd    err
    // basic write
    row(0, 1, 0, 0, 12'h000, 0,     0,  0, 0,  0, 12'h000, 0, 0, 12'h000, 0,    0, 0,    0);
    row(1, 0, 0, 0, 12'h000, 0,     0,  0, 0,  1, 12'h300, 0, 0, 12'h000, 0,    0, 0,    0);
    row(1, 0, 0, 1, 12'h300, 'hA5,  3,  0, 0,  1, 12'h300, 0, 0, 12'h000, 0,    0, 0,    0);
    row(1, 0, 0, 0, 12'h000, 0,     0,  0, 0,  1, 12'h300, 0, 0, 12'h000, 0,    1, 'hA5, 0);
    row(1, 0, 0, 0, 12'h000, 0,     0,  1, 3,  1, 12'h300, 0, 0, 12'h000, 0,    1, 'hA5, 0);
    row(1, 0, 0, 0, 12'h000, 0,     0,  0, 0,  1, 12'h300, 0, 1, 12'h300, 'hA5, 0, 0,    0);
    row(1, 0, 0, 0, 12'h000, 0,     0,  0, 0,  0, 12'h000, 0, 0, 12'h000, 0,    0, 0,    0);
    // forwarding: youngest match wins, other address misses
    row(1, 0, 0, 1, 12'h340, 'h11,  1,  0, 0,  0, 12'h000, 0, 0, 12'h000, 0,    0, 0,    0);
    row(1, 0, 0, 1, 12'h340, 'h22,  2,  0, 0,  1, 12'h340, 0, 0, 12'h000, 0,    1, 'h11, 0);
    row(1, 0, 0, 0, 12'h000, 0,     0,  0, 0,  1, 12'h340, 0, 0, 12'h000, 0,    1, 'h22, 0);
    row(1, 0, 0, 0, 12'h000, 0,     0,  0, 0,  1, 12'h341, 0, 0, 12'h000, 0,    0, 0,    0);
    row(1, 0, 0, 0, 12'h000, 0,     0,  1, 1,  0, 12'h000, 0, 0, 12'h000, 0,    0, 0,    0);
    row(1, 0, 0, 0, 12'h000, 0,     0,  1, 2,  0, 12'h000, 0, 1, 12'h340, 'h11, 0, 0,    0);
    row(1, 0, 0, 0, 12'h000, 0,     0,  0, 0,  0, 12'h000, 0, 1, 12'h340, 'h22, 0, 0,    0);
    row(1, 0, 0, 0, 12'h000, 0,     0,  0, 0,  0, 12'h000, 0, 0, 12'h000, 0,    0, 0,    0);
    // full / wrap: fifth enqueue alongside a head commit
    row(1, 0, 0, 1, 12'h301, 'hD1,  4,  0, 0,  0, 12'h000, 0, 0, 12'h000, 0,    0, 0,    0);
    row(1, 0, 0, 1, 12'h302, 'hD2,  5,  0, 0,  0, 12'h000, 0, 0, 12'h000, 0,    0, 0,    0);
    row(1, 0, 0, 1, 12'h303, 'hD3,  6,  0, 0,  0, 12'h000, 0, 0, 12'h000, 0,    0, 0,    0);
    row(1, 0, 0, 1, 12'h304, 'hD4,  7,  0, 0,  0, 12'h000, 0, 0, 12'h000, 0,    0, 0,    0);
    row(1, 0, 0, 1, 12'h305, 'hD5,  8,  1, 4,  1, 12'h305, 1, 0, 12'h000, 0,    0, 0,    0);
    row(1, 0, 0, 0, 12'h000, 0,     0,  1, 5,  1, 12'h305, 1, 1, 12'h301, 'hD1, 1, 'hD5, 0);
    row(1, 0, 0, 0, 12'h000, 0,     0,  1, 6,  0, 12'h000, 0, 1, 12'h302, 'hD2, 0, 0,    0);
    row(1, 0, 0, 0, 12'h000, 0,     0,  1, 7,  0, 12'h000, 0, 1, 12'h303, 'hD3, 0, 0,    0);
    row(1, 0, 0, 0, 12'h000, 0,     0,  1, 8,  0, 12'h000, 0, 1, 12'h304, 'hD4, 0, 0,    0);
    row(1, 0, 0, 0, 12'h000, 0,     0,  0, 0,  0, 12'h000, 0, 1, 12'h305, 'hD5, 0, 0,    0);
    // recovery with a same-cycle legal commit and a discarded enqueue
    row(1, 0, 0, 1, 12'h310, 'hA1, 10,  0, 0,  0, 12'h000, 0, 0, 12'h000, 0,    0, 0,    0);
    row(1, 0, 0, 1, 12'h311, 'hA2, 11,  0, 0,  0, 12'h000, 0, 0, 12'h000, 0,    0, 0,    0);
    row(1, 0, 0, 1, 12'h312, 'hA3, 12,  0, 0,  0, 12'h000, 0, 0, 12'h000, 0,    0, 0,    0);
    row(1, 0, 1, 1, 12'h313, 'hA4, 13,  1, 10, 1, 12'h311, 0, 0, 12'h000, 0,    1, 'hA2, 0);
    row(1, 0, 0, 0, 12'h000, 0,     0,  0, 0,  1, 12'h311, 0, 1, 12'h310, 'hA1, 0, 0,    0);
    row(1, 0, 0, 0, 12'h000, 0,     0,  0, 0,  1, 12'h313, 0, 0, 12'h000, 0,    0, 0,    0);
    // errors: alID mismatch keeps head, then commit on empty
    row(1, 0, 0, 1, 12'h320, 'hB5,  5,  0, 0,  0, 12'h000, 0, 0, 12'h000, 0,    0, 0,    0);
    row(1, 0, 0, 0, 12'h000, 0,     0,  1, 7,  1, 12'h320, 0, 0, 12'h000, 0,    1, 'hB5, 0);
    row(1, 0, 0, 0, 12'h000, 0,     0,  0, 0,  1, 12'h320, 0, 0, 12'h000, 0,    1, 'hB5, 1);
    row(1, 0, 0, 0, 12'h000, 0,     0,  1, 5,  0, 12'h000, 0, 0, 12'h000, 0,    0, 0,    1);
    row(1, 0, 0, 0, 12'h000, 0,     0,  0, 0,  0, 12'h000, 0, 1, 12'h320, 'hB5, 0, 0,    1);
    row(1, 0, 0, 0, 12'h000, 0,     0,  1, 1,  0, 12'h000, 0, 0, 12'h000, 0,    0, 0,    1);
    row(1, 0, 0, 0, 12'h000, 0,     0,  0, 0,  0, 12'h000, 0, 0, 12'h000, 0,    0, 0,    1);
    // reset mid-operation with a commit in flight
    row(1, 0, 0, 1, 12'h330, 'hC1,  1,  0, 0,  0, 12'h000, 0, 0, 12'h000, 0,    0, 0,    1);
    row(1, 0, 0, 1, 12'h331, 'hC2,  2,  0, 0,  0, 12'h000, 0, 0, 12'h000, 0,    0, 0,    1);
    row(1, 1, 0, 0, 12'h000, 0,     0,  1, 1,  1, 12'h330, 0, 0, 12'h000, 0,    1, 'hC1, 1);
    row(1, 0, 0, 0, 12'h000, 0,     0,  0, 0,  1, 12'h330, 0, 0, 12'h000, 0,    0, 0,    0);
    row(1, 0, 0, 1, 12'h330, 'hC3,  3,  0, 0,  0, 12'h000, 0, 0, 12'h000, 0,    0, 0,    0);
    row(1, 0, 0, 0, 12'h000, 0,     0,  1, 3,  1, 12'h330, 0, 0, 12'h000, 0,    1, 'hC3, 0);
    row(1, 0, 0, 0, 12'h000, 0,     0,  0, 0,  0, 12'h000, 0, 1, 12'h330, 'hC3, 0, 0,    0);
    // enqueue while full without a pop is dropped and flags an error
    row(1, 0, 0, 1, 12'h350, 'hE0, 20,  0, 0,  0, 12'h000, 0, 0, 12'h000, 0,    0, 0,    0);
    row(1, 0, 0, 1, 12'h351, 'hE1, 21,  0, 0,  0, 12'h000, 0, 0, 12'h000, 0,    0, 0,    0);
    row(1, 0, 0, 1, 12'h352, 'hE2, 22,  0, 0,  0, 12'h000, 0, 0, 12'h000, 0,    0, 0,    0);
    row(1, 0, 0, 1, 12'h353, 'hE3, 23,  0, 0,  0, 12'h000, 0, 0, 12'h000, 0,    0, 0,    0);
    row(1, 0, 0, 1, 12'h354, 'hE4, 24,  0, 0,  1, 12'h350, 1, 0, 12'h000, 0,    1, 'hE0, 0);
    row(1, 0, 0, 0, 12'h000, 0,     0,  0, 0,  1, 12'h354, 1, 0, 12'h000, 0,    0, 0,    1);
    row(1, 0, 1, 0, 12'h000, 0,     0,  0, 0,  1, 12'h353, 1, 0, 12'h000, 0,    1, 'hE3, 1);
    row(1, 0, 0, 0, 12'h000, 0,     0,  0, 0,  1, 12'h353, 0, 0, 12'h000, 0,    0, 0,    1);

    foreach (vecs[r]) begin
      drive(vecs[r].rst, vecs[r].rec, vecs[r].ev, vecs[r].ea, vecs[r].ed, vecs[r].eal,
            vecs[r].cv, vecs[r].cal, vecs[r].ren, vecs[r].ra);
      #1;
      if (vecs[r].chk) begin
        check("full", r, 32'(full), 32'(vecs[r].xFull));
        check("wrEn", r, 32'(csrWrEn), 32'(vecs[r].xWr));
        if (vecs[r].xWr) begin
          check("wrAddr", r, 32'(csrWrAddr), 32'(vecs[r].xWa));
          check("wrData", r, csrWrData, vecs[r].xWd);
        end
        check("fwdHit", r, 32'(fwdHit), 32'(vecs[r].xHit));
        check("fwdData", r, fwdData, vecs[r].xFd);
        check("commitErr", r, 32'(commitErr), 32'(vecs[r].xErr));
      end
      @(posedge clk);
      #1;
    end

    // Steady state: enqueue and commit the previous entry every cycle.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    for (int k = 0; k <= 10; k++) begin
      drive(0, 0, (k < 8), 12'h360, 32'h1000 + 32'(k), 7'(k), (k >= 1 && k <= 8), 7'(k - 1), 0, 0);
      #1;
      if (k >= 2 && k <= 9) begin
        check("b2b_wrEn", 100 + k, 32'(csrWrEn), 32'd1);
        check("b2b_wrData", 100 + k, csrWrData, 32'h1000 + 32'(k - 2));
      end else if (k == 10) begin
        check("b2b_idle_wrEn", 100 + k, 32'(csrWrEn), 32'd0);
        check("b2b_full", 100 + k, 32'(full), 32'd0);
        check("b2b_err", 100 + k, 32'(commitErr), 32'd0);
      end
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
